ex_hazard_ctrl: RTL

EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

---
 rtl/ex_hazard_ctrl_pkg.sv | 21 ++
 rtl/ex_hazard_ctrl_slot.sv | 19 +
 rtl/ex_hazard_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared execute-stage definitions: forwarding select encodings
// and the bit layout of a hazard shadow slot.
package ex_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        SEL_MUX    = 2'b00,
        SEL_WB     = 2'b01,
        SEL_ALU_EM = 2'b10,
        SEL_ALU_MW = 2'b11
    } fwd_sel_e;

    // Slot = {valid, rd[RW-1:0], wb_en, mem_read}; valid is the MSB.
    localparam int SLOT_MR = 0;
    localparam int SLOT_WB = 1;
    localparam int SLOT_RD = 2;

    function automatic int slot_w(int rw);
        return rw + 3;
    endfunction

endpackage

// File: rtl/ex_hazard_ctrl_slot.sv
// One pipeline shadow slot: enabled load with synchronous clear.
module hz_slot #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Load-use stall and forwarding-select generation for the
// execute stage, tracking D/E, E/M and M/W producers.
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
#(
    parameter int RW = 3,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rsrc,
    input  logic [RW-1:0] id_rdst,
    input  logic          id_use_src,
    input  logic          id_use_dst,
    input  logic          id_wb_en,
    input  logic          id_mem_read,
    input  logic          hold,
    input  logic          flush,
    output logic          stall,
    output logic          ex_bubble,
    output logic [1:0]    FU_Src_Sel,
    output logic [1:0]    FU_Dst_Sel,
    output logic [CW-1:0] stall_count
);

    localparam int SW = slot_w(RW);

    logic [SW-1:0] exs_q;
    logic [SW-1:0] mems_q;
    logic [SW-1:0] wbs_q;
    logic [SW-1:0] exs_d;
    logic          adv;
    logic          kill;
    logic          load_use;
    logic          wbs_unused;

    function automatic logic hit(
        logic [SW-1:0] s,
        logic [RW-1:0] r
    );
        return s[SW-1] & s[SLOT_WB] & (s[SLOT_RD +: RW] == r);
    endfunction

    function automatic logic [1:0] pick(
        logic          en,
        logic [RW-1:0] r,
        logic          is_dst,
        logic [SW-1:0] ex,
        logic [SW-1:0] mem
    );
        if (!en)
            return SEL_MUX;
        if (hit(ex, r) & !ex[SLOT_MR])
            return SEL_ALU_EM;
        if (hit(mem, r) & mem[SLOT_MR])
            return SEL_WB;
        // Dst operand has no M/W ALU path; fall back to write-back.
        if (hit(mem, r))
            return is_dst ? SEL_WB : SEL_ALU_MW;
        return SEL_MUX;
    endfunction

    assign adv = !hold;

    assign load_use = id_valid & exs_q[SLOT_MR]
        & ((id_use_src & hit(exs_q, id_rsrc))
         | (id_use_dst & hit(exs_q, id_rdst)));

    assign stall     = load_use & !hold & !flush & !rst;
    assign ex_bubble = stall;
    assign kill      = stall | flush;

    assign exs_d = {id_valid & !kill, id_rdst,
                    id_wb_en, id_mem_read};

    hz_slot #(.W(SW)) u_exs (
        .clk (clk),
        .clr (rst),
        .en  (adv),
        .d   (exs_d),
        .q   (exs_q)
    );

    hz_slot #(.W(SW)) u_mems (
        .clk (clk),
        .clr (rst),
        .en  (adv),
        .d   (exs_q),
        .q   (mems_q)
    );

    hz_slot #(.W(SW)) u_wbs (
        .clk (clk),
        .clr (rst),
        .en  (adv),
        .d   (mems_q),
        .q   (wbs_q)
    );

    // M/W mirror is kept for pipeline symmetry; no select reads it.
    assign wbs_unused = ^wbs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            FU_Src_Sel  <= SEL_MUX;
            FU_Dst_Sel  <= SEL_MUX;
            stall_count <= '0;
        end else if (adv) begin
            if (kill) begin
                FU_Src_Sel <= SEL_MUX;
                FU_Dst_Sel <= SEL_MUX;
            end else begin
                FU_Src_Sel <= pick(id_use_src, id_rsrc, 1'b0,
                                   exs_q, mems_q);
                FU_Dst_Sel <= pick(id_use_dst, id_rdst, 1'b1,
                                   exs_q, mems_q);
            end
            if (stall && stall_count != {CW{1'b1}})
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule
